arbitro_jogadores: RTL and testbench

- Buzzer arbiter and answer sequencer for the multi-player quiz mode.
- Sits between the player button inputs and the main game control unit. After the control unit has shown a question, the control unit opens a buzzer window.
- This block grants exactly one player the right to answer and times that player's answer. It locks out players who answer wrongly or time out, and reports a single round outcome.

---
 rtl/pj_pkg.sv | 23 ++
 rtl/arbitro_rr.sv | 35 +++
 rtl/arbitro_jogadores.sv | 209 ++++++++++++++++++++
 tb/tb_arbitro_jogadores.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pj_pkg.sv
// Shared definitions for the quiz-mode buzzer arbiter: FSM state codes,
// default sizing and a small helper used to size the round timer.
package pj_pkg;

    typedef enum logic [2:0] {
        OCIOSO          = 3'd0,
        ESPERA_BOTAO    = 3'd1,
        ESPERA_RESPOSTA = 3'd2,
        AVALIA          = 3'd3,
        VERIFICA        = 3'd4,
        FIM             = 3'd5
    } estado_t;

    localparam int N_JOG_PAD      = 4;
    localparam int T_JANELA_PAD   = 5000;
    localparam int T_RESPOSTA_PAD = 3000;

    // Larger of two integers, used for the shared window/answer timer width.
    function automatic int pj_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/arbitro_rr.sv
// Combinational round-robin picker: returns the first requesting index found
// when scanning upward (with wrap-around) from ponteiro.
module arbitro_rr
    import pj_pkg::*;
#(
    parameter int N_JOG = N_JOG_PAD,
    parameter int W     = $clog2(N_JOG)
) (
    input  logic [N_JOG-1:0] req,
    input  logic [W-1:0]     ponteiro,
    output logic [W-1:0]     grant_idx,
    output logic             valid
);

    logic [W:0]   soma_s;
    logic [W-1:0] idx_s;
    logic         hit_s;

    // Scan all players starting at ponteiro; the first request seen wins.
    always_comb begin
        grant_idx = '0;
        valid     = 1'b0;
        soma_s    = '0;
        idx_s     = '0;
        hit_s     = 1'b0;
        for (int i = 0; i < N_JOG; i++) begin
            soma_s    = {1'b0, ponteiro} + (W+1)'(i);
            idx_s     = (soma_s >= (W+1)'(N_JOG)) ? W'(soma_s - (W+1)'(N_JOG)) : W'(soma_s);
            hit_s     = req[idx_s] & ~valid;
            grant_idx = hit_s ? idx_s : grant_idx;
            valid     = valid | req[idx_s];
        end
    end

endmodule

// File: rtl/arbitro_jogadores.sv
// Buzzer arbiter and answer sequencer for multi-player quiz mode. Grants one
// player at a time, times the answer, locks out wrong/late players and
// reports a single outcome pulse per round.
module arbitro_jogadores
    import pj_pkg::*;
#(
    parameter int N_JOG      = N_JOG_PAD,
    parameter int T_JANELA   = T_JANELA_PAD,
    parameter int T_RESPOSTA = T_RESPOSTA_PAD,
    localparam int W         = $clog2(N_JOG)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             abrir,
    input  logic             cancelar,
    input  logic [N_JOG-1:0] botoes,
    input  logic             resposta_valida,
    input  logic             resposta_certa,
    output logic [N_JOG-1:0] concede,
    output logic [W-1:0]     vencedor,
    output logic [N_JOG-1:0] bloqueados,
    output logic             registraR,
    output logic             acertou,
    output logic             errou_todos,
    output logic             timeout,
    output logic             ocupado,
    output logic [2:0]       db_estado
);

    localparam int TW = $clog2(pj_max(pj_max(T_JANELA, T_RESPOSTA), 2));

    estado_t          estado_r, estado_s;
    logic [TW-1:0]    tmr_r;
    logic [W-1:0]     vencedor_r;
    logic [W-1:0]     ponteiro_r;
    logic [N_JOG-1:0] bloqueados_r;
    logic [N_JOG-1:0] botoes_d_r;
    logic             certa_r;

    logic [N_JOG-1:0] borda_s;
    logic [N_JOG-1:0] elegiveis_s;
    logic [N_JOG-1:0] venc_oh_s;
    logic [W-1:0]     rr_idx_s;
    logic             rr_valid_s;

    logic tmr_zera_s, tmr_inc_s, latch_s, bloq_set_s, bloq_clr_s, certa_load_s;

    // Rising-edge detect so a held button cannot retrigger; locked players masked.
    assign borda_s     = botoes & ~botoes_d_r;
    assign elegiveis_s = borda_s & ~bloqueados_r;
    assign venc_oh_s   = N_JOG'(1) << vencedor_r;

    arbitro_rr #(
        .N_JOG (N_JOG),
        .W     (W)
    ) u_rr (
        .req       (elegiveis_s),
        .ponteiro  (ponteiro_r),
        .grant_idx (rr_idx_s),
        .valid     (rr_valid_s)
    );

    assign concede    = (estado_r == ESPERA_RESPOSTA) ? venc_oh_s : '0;
    assign vencedor   = vencedor_r;
    assign bloqueados = bloqueados_r;
    assign ocupado    = (estado_r != OCIOSO);
    assign db_estado  = estado_r;

    // Next-state, outcome pulses and datapath strobes; cancelar beats everything.
    always_comb begin
        estado_s     = estado_r;
        registraR    = 1'b0;
        acertou      = 1'b0;
        errou_todos  = 1'b0;
        timeout      = 1'b0;
        tmr_zera_s   = 1'b0;
        tmr_inc_s    = 1'b0;
        latch_s      = 1'b0;
        bloq_set_s   = 1'b0;
        bloq_clr_s   = 1'b0;
        certa_load_s = 1'b0;
        if (cancelar) begin
            estado_s = OCIOSO;
        end else begin
            case (estado_r)
                OCIOSO: begin
                    if (abrir) begin
                        estado_s   = ESPERA_BOTAO;
                        bloq_clr_s = 1'b1;
                        tmr_zera_s = 1'b1;
                    end else begin
                        estado_s = OCIOSO;
                    end
                end
                ESPERA_BOTAO: begin
                    // A press in the last window cycle still wins over timeout.
                    if (rr_valid_s) begin
                        latch_s    = 1'b1;
                        tmr_zera_s = 1'b1;
                        estado_s   = ESPERA_RESPOSTA;
                    end else if (tmr_r == TW'(T_JANELA - 1)) begin
                        timeout  = 1'b1;
                        estado_s = FIM;
                    end else begin
                        tmr_inc_s = 1'b1;
                    end
                end
                ESPERA_RESPOSTA: begin
                    // An answer arriving on the deadline cycle is accepted.
                    if (resposta_valida) begin
                        registraR    = 1'b1;
                        certa_load_s = 1'b1;
                        estado_s     = AVALIA;
                    end else if (tmr_r == TW'(T_RESPOSTA - 1)) begin
                        bloq_set_s = 1'b1;
                        estado_s   = VERIFICA;
                    end else begin
                        tmr_inc_s = 1'b1;
                    end
                end
                AVALIA: begin
                    if (certa_r) begin
                        acertou  = 1'b1;
                        estado_s = FIM;
                    end else begin
                        bloq_set_s = 1'b1;
                        estado_s   = VERIFICA;
                    end
                end
                VERIFICA: begin
                    if (&bloqueados_r) begin
                        errou_todos = 1'b1;
                        estado_s    = FIM;
                    end else begin
                        tmr_zera_s = 1'b1;
                        estado_s   = ESPERA_BOTAO;
                    end
                end
                FIM: begin
                    estado_s = OCIOSO;
                end
                default: begin
                    estado_s = OCIOSO;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_r <= OCIOSO;
        end else begin
            estado_r <= estado_s;
        end
    end

    // Shared window/answer timer; every compare forces a state exit so it never wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmr_r <= '0;
        end else if (tmr_zera_s) begin
            tmr_r <= '0;
        end else if (tmr_inc_s) begin
            tmr_r <= tmr_r + TW'(1);
        end else begin
            tmr_r <= tmr_r;
        end
    end

    // Winner latch and round-robin pointer, which persists across rounds.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vencedor_r <= '0;
            ponteiro_r <= '0;
        end else if (latch_s) begin
            vencedor_r <= rr_idx_s;
            ponteiro_r <= (rr_idx_s == W'(N_JOG - 1)) ? '0 : rr_idx_s + W'(1);
        end else begin
            vencedor_r <= vencedor_r;
            ponteiro_r <= ponteiro_r;
        end
    end

    // Lockout mask: cleared on a new round, kept through cancel and FIM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bloqueados_r <= '0;
        end else if (bloq_clr_s) begin
            bloqueados_r <= '0;
        end else if (bloq_set_s) begin
            bloqueados_r <= bloqueados_r | venc_oh_s;
        end else begin
            bloqueados_r <= bloqueados_r;
        end
    end

    // Previous-button sample for edge detection and the latched comparator result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            botoes_d_r <= '0;
            certa_r    <= 1'b0;
        end else begin
            botoes_d_r <= botoes;
            certa_r    <= certa_load_s ? resposta_certa : certa_r;
        end
    end

endmodule

// File: tb/tb_arbitro_jogadores.sv
// Self-checking bench for arbitro_jogadores: a 4-player instance driven from a
// vector table, plus a 2-player instance for the everyone-wrong round.
module tb_arbitro_jogadores;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // 4-player instance, short timers
    logic       abrir = 1'b0, cancelar = 1'b0, rv = 1'b0, rc = 1'b0;
    logic [3:0] botoes = 4'b0000;
    logic [3:0] concede, bloqueados;
    logic [1:0] vencedor;
    logic       registraR, acertou, errou_todos, timeout, ocupado;
    logic [2:0] db_estado;

    arbitro_jogadores #(.N_JOG(4), .T_JANELA(8), .T_RESPOSTA(5)) u_dut (
        .clock(clock), .reset(reset), .abrir(abrir), .cancelar(cancelar),
        .botoes(botoes), .resposta_valida(rv), .resposta_certa(rc),
        .concede(concede), .vencedor(vencedor), .bloqueados(bloqueados),
        .registraR(registraR), .acertou(acertou), .errou_todos(errou_todos),
        .timeout(timeout), .ocupado(ocupado), .db_estado(db_estado)
    );

    wire [17:0] saida = {concede, vencedor, bloqueados,
                         registraR, acertou, errou_todos, timeout, ocupado, db_estado};

    // 2-player instance
    logic       abrir2 = 1'b0, rv2 = 1'b0, rc2 = 1'b0;
    logic [1:0] botoes2 = 2'b00;
    logic [1:0] concede2, bloqueados2;
    logic [0:0] vencedor2;
    logic       registraR2, acertou2, errou_todos2, timeout2, ocupado2;
    logic [2:0] db_estado2;

    arbitro_jogadores #(.N_JOG(2), .T_JANELA(8), .T_RESPOSTA(5)) u_dut2 (
        .clock(clock), .reset(reset), .abrir(abrir2), .cancelar(1'b0),
        .botoes(botoes2), .resposta_valida(rv2), .resposta_certa(rc2),
        .concede(concede2), .vencedor(vencedor2), .bloqueados(bloqueados2),
        .registraR(registraR2), .acertou(acertou2), .errou_todos(errou_todos2),
        .timeout(timeout2), .ocupado(ocupado2), .db_estado(db_estado2)
    );

    wire [7:0] saida2 = {errou_todos2, ocupado2, vencedor2, bloqueados2, db_estado2};

    typedef struct {
        logic       abrir, cancelar;
        logic [3:0] botoes;
        logic       rv, rc;
        logic [17:0] saida;
    } vec_t;

    typedef struct {
        logic       abrir;
        logic [1:0] botoes;
        logic       rv, rc;
        logic [7:0] saida;
    } vec2_t;

    vec_t        tab[$];
    vec2_t       tab2[$];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          fim_a;
    int          errou_cnt = 0;
    logic [31:0] esperado;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // row(abrir, cancelar, botoes, rv, rc | concede, vencedor, bloqueados, {reg,acert,errou,tout}, ocupado, estado)
    task automatic row(input logic a, input logic c, input logic [3:0] b, input logic v, input logic r,
                       input logic [3:0] con, input logic [1:0] ven, input logic [3:0] blq,
                       input logic [3:0] pul, input logic oc, input logic [2:0] st);
        vec_t x;
        x.abrir = a; x.cancelar = c; x.botoes = b; x.rv = v; x.rc = r;
        x.saida = {con, ven, blq, pul, oc, st};
        tab.push_back(x);
    endtask

    task automatic row2(input logic a, input logic [1:0] b, input logic v, input logic r,
                        input logic er, input logic oc, input logic ven, input logic [1:0] blq,
                        input logic [2:0] st);
        vec2_t x;
        x.abrir = a; x.botoes = b; x.rv = v; x.rc = r;
        x.saida = {er, oc, ven, blq, st};
        tab2.push_back(x);
    endtask

    task automatic run_tab(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(negedge clock);
            abrir = tab[i].abrir; cancelar = tab[i].cancelar; botoes = tab[i].botoes;
            rv = tab[i].rv; rc = tab[i].rc;
            exp_q.push_back(32'(tab[i].saida));
            #1;
            esperado = exp_q.pop_front();
            chk($sformatf("vec%0d", i), 32'(saida), esperado);
        end
        @(negedge clock);
        abrir = 1'b0; cancelar = 1'b0; botoes = 4'b0000; rv = 1'b0; rc = 1'b0;
    endtask

    initial begin
        // Round 1: single press by player 1, correct answer
        row(1,0,4'b0000,0,0, 4'b0000,2'd0,4'b0000,4'b0000,0,3'd0);
        row(0,0,4'b0010,0,0, 4'b0000,2'd0,4'b0000,4'b0000,1,3'd1);
        row(0,0,4'b0000,0,0, 4'b0010,2'd1,4'b0000,4'b0000,1,3'd2);
        row(0,0,4'b0000,1,1, 4'b0010,2'd1,4'b0000,4'b1000,1,3'd2);
        row(0,0,4'b0000,0,0, 4'b0000,2'd1,4'b0000,4'b0100,1,3'd3);
        row(0,0,4'b0000,0,0, 4'b0000,2'd1,4'b0000,4'b0000,1,3'd5);
        row(0,0,4'b0000,0,0, 4'b0000,2'd1,4'b0000,4'b0000,0,3'd0);
        // Round 2: pointer 2, simultaneous 1010 -> player 3, wrong answer
        row(1,0,4'b0000,0,0, 4'b0000,2'd1,4'b0000,4'b0000,0,3'd0);
        row(0,0,4'b1010,0,0, 4'b0000,2'd1,4'b0000,4'b0000,1,3'd1);
        row(0,0,4'b1010,0,0, 4'b1000,2'd3,4'b0000,4'b0000,1,3'd2);
        row(0,0,4'b0000,1,0, 4'b1000,2'd3,4'b0000,4'b1000,1,3'd2);
        row(0,0,4'b0000,0,0, 4'b0000,2'd3,4'b0000,4'b0000,1,3'd3);
        row(0,0,4'b0000,0,0, 4'b0000,2'd3,4'b1000,4'b0000,1,3'd4);
        // locked player 3 alone ignored, then together with player 0 -> player 0
        row(0,0,4'b1000,0,0, 4'b0000,2'd3,4'b1000,4'b0000,1,3'd1);
        row(0,0,4'b0000,0,0, 4'b0000,2'd3,4'b1000,4'b0000,1,3'd1);
        row(0,0,4'b1001,0,0, 4'b0000,2'd3,4'b1000,4'b0000,1,3'd1);
        // player 0 never answers: locked after 5 cycles, back to window
        for (int k = 0; k < 5; k++) row(0,0,4'b0000,0,0, 4'b0001,2'd0,4'b1000,4'b0000,1,3'd2);
        row(0,0,4'b0000,0,0, 4'b0000,2'd0,4'b1001,4'b0000,1,3'd4);
        // press in the final window cycle beats the window timeout
        for (int k = 0; k < 7; k++) row(0,0,4'b0000,0,0, 4'b0000,2'd0,4'b1001,4'b0000,1,3'd1);
        row(0,0,4'b0100,0,0, 4'b0000,2'd0,4'b1001,4'b0000,1,3'd1);
        // answer on the deadline cycle wins over the answer timeout
        for (int k = 0; k < 4; k++) row(0,0,4'b0000,0,0, 4'b0100,2'd2,4'b1001,4'b0000,1,3'd2);
        row(0,0,4'b0000,1,0, 4'b0100,2'd2,4'b1001,4'b1000,1,3'd2);
        row(0,0,4'b0000,0,0, 4'b0000,2'd2,4'b1001,4'b0000,1,3'd3);
        row(0,0,4'b0000,0,0, 4'b0000,2'd2,4'b1101,4'b0000,1,3'd4);
        // last eligible player 1 wrong -> everyone locked
        row(0,0,4'b0010,0,0, 4'b0000,2'd2,4'b1101,4'b0000,1,3'd1);
        row(0,0,4'b0000,1,0, 4'b0010,2'd1,4'b1101,4'b1000,1,3'd2);
        row(0,0,4'b0000,0,0, 4'b0000,2'd1,4'b1101,4'b0000,1,3'd3);
        row(0,0,4'b0000,0,0, 4'b0000,2'd1,4'b1111,4'b0010,1,3'd4);
        row(0,0,4'b0000,0,0, 4'b0000,2'd1,4'b1111,4'b0000,1,3'd5);
        row(0,0,4'b0000,0,0, 4'b0000,2'd1,4'b1111,4'b0000,0,3'd0);
        // window timeout; stray answer and abrir inside the window are ignored
        row(1,0,4'b0000,0,0, 4'b0000,2'd1,4'b1111,4'b0000,0,3'd0);
        row(0,0,4'b0000,1,1, 4'b0000,2'd1,4'b0000,4'b0000,1,3'd1);
        row(1,0,4'b0000,0,0, 4'b0000,2'd1,4'b0000,4'b0000,1,3'd1);
        for (int k = 0; k < 5; k++) row(0,0,4'b0000,0,0, 4'b0000,2'd1,4'b0000,4'b0000,1,3'd1);
        row(0,0,4'b0000,0,0, 4'b0000,2'd1,4'b0000,4'b0001,1,3'd1);
        row(0,0,4'b0000,0,0, 4'b0000,2'd1,4'b0000,4'b0000,1,3'd5);
        row(0,0,4'b0000,0,0, 4'b0000,2'd1,4'b0000,4'b0000,0,3'd0);
        // cancel during answer wait: no outcome pulse
        row(1,0,4'b0000,0,0, 4'b0000,2'd1,4'b0000,4'b0000,0,3'd0);
        row(0,0,4'b0001,0,0, 4'b0000,2'd1,4'b0000,4'b0000,1,3'd1);
        row(0,0,4'b0000,0,0, 4'b0001,2'd0,4'b0000,4'b0000,1,3'd2);
        row(0,1,4'b0000,0,0, 4'b0001,2'd0,4'b0000,4'b0000,1,3'd2);
        row(0,0,4'b0000,0,0, 4'b0000,2'd0,4'b0000,4'b0000,0,3'd0);
        fim_a = tab.size();
        // After reset the pointer is 0 again: 1010 -> player 1
        row(1,0,4'b0000,0,0, 4'b0000,2'd0,4'b0000,4'b0000,0,3'd0);
        row(0,0,4'b1010,0,0, 4'b0000,2'd0,4'b0000,4'b0000,1,3'd1);
        row(0,0,4'b0000,0,0, 4'b0010,2'd1,4'b0000,4'b0000,1,3'd2);
        row(0,1,4'b0000,0,0, 4'b0010,2'd1,4'b0000,4'b0000,1,3'd2);
        row(0,0,4'b0000,0,0, 4'b0000,2'd1,4'b0000,4'b0000,0,3'd0);

        // 2 players, both wrong: row2(abrir, botoes, rv, rc | errou, ocupado, vencedor, bloqueados, estado)
        row2(1,2'b00,0,0, 0,0,0,2'b00,3'd0);
        row2(0,2'b01,0,0, 0,1,0,2'b00,3'd1);
        row2(0,2'b00,1,0, 0,1,0,2'b00,3'd2);
        row2(0,2'b00,0,0, 0,1,0,2'b00,3'd3);
        row2(0,2'b00,0,0, 0,1,0,2'b01,3'd4);
        row2(0,2'b10,0,0, 0,1,0,2'b01,3'd1);
        row2(0,2'b00,1,0, 0,1,1,2'b01,3'd2);
        row2(0,2'b00,0,0, 0,1,1,2'b01,3'd3);
        row2(0,2'b00,0,0, 1,1,1,2'b11,3'd4);
        row2(0,2'b00,0,0, 0,1,1,2'b11,3'd5);
        row2(0,2'b00,0,0, 0,0,1,2'b11,3'd0);

        // Reset state
        repeat (2) @(negedge clock);
        #1;
        chk("reset_out", 32'(saida), 32'd0);
        chk("reset_out2", 32'(saida2), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        run_tab(0, fim_a);

        // Async reset in the middle of a cycle while a grant is held
        @(negedge clock); abrir = 1'b1;
        @(negedge clock); abrir = 1'b0; botoes = 4'b0100;
        @(negedge clock); botoes = 4'b0000;
        #1;
        chk("grant_before_reset", 32'(concede), 32'h4);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_out", 32'(saida), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        run_tab(fim_a, tab.size());

        for (int i = 0; i < tab2.size(); i++) begin
            @(negedge clock);
            abrir2 = tab2[i].abrir; botoes2 = tab2[i].botoes;
            rv2 = tab2[i].rv; rc2 = tab2[i].rc;
            exp_q.push_back(32'(tab2[i].saida));
            #1;
            if (errou_todos2) errou_cnt++;
            esperado = exp_q.pop_front();
            chk($sformatf("two_players%0d", i), 32'(saida2), esperado);
        end
        chk("errou_todos_pulses", 32'(errou_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
